vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; the successor to the fixed 640x480 clock divider and sync pair in the VGA top level. It produces a pixel clock-enable from the system clock and walks the horizontal and vertical counters. It emits sync and blank for any resolution and porch set, with programmable sync polarity. Sync and blank can be delayed to match renderer pipeline latency. It also provides start-of-frame and frame-count outputs for animation and player logic.

---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel clock-enable, H/V counters,
// programmable-polarity sync, pipelined sync/blank and frame events.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE     = 1,
    parameter int FRAME_W  = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_ce,
    output logic               vga_clk,
    output logic [XW-1:0]      pixelx,
    output logic [YW-1:0]      pixely,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               sync,
    output logic               sof,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'((CLK_DIV + 1) / 2);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DW-1:0]      r_div;
    logic [DW-1:0]      w_div_nxt;
    logic               r_ce;
    logic               r_vga_clk;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [FRAME_W-1:0] r_frame;

    logic w_ce;
    logic w_x_last;
    logic w_y_last;
    logic w_active;
    logic w_hs;
    logic w_vs;

    // r_ce is held while en is low, so masking with en keeps pix_ce quiet
    // during a freeze and lets the pending pixel fire on resume.
    always_comb begin
        w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
        w_ce      = en & r_ce;
        w_x_last  = (r_x == X_LAST);
        w_y_last  = (r_y == Y_LAST);
        w_active  = (r_x < X_ACT) && (r_y < Y_ACT);
        w_hs      = ((r_x >= HS_START) && (r_x <= HS_END)) ? HS_ON : ~HS_ON;
        w_vs      = ((r_y >= VS_START) && (r_y <= VS_END)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_ce      <= 1'b0;
            r_vga_clk <= 1'b0;
        end else if (en) begin
            r_div     <= w_div_nxt;
            r_ce      <= (r_div == DIV_LAST);
            r_vga_clk <= (w_div_nxt < DIV_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else if (w_ce) begin
            r_x <= w_x_last ? '0 : r_x + XW'(1);
            if (w_x_last) begin
                r_y <= w_y_last ? '0 : r_y + YW'(1);
                if (w_y_last) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign hsync = w_hs;
            assign vsync = w_vs;
            assign blank = w_active;
        end else begin : g_pipe
            logic [PIPE-1:0] r_hs_d;
            logic [PIPE-1:0] r_vs_d;
            logic [PIPE-1:0] r_bl_d;

            // Shift in at bit 0; the size cast drops the oldest stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hs_d <= {PIPE{~HS_ON}};
                    r_vs_d <= {PIPE{~VS_ON}};
                    r_bl_d <= '0;
                end else if (w_ce) begin
                    r_hs_d <= PIPE'({r_hs_d, w_hs});
                    r_vs_d <= PIPE'({r_vs_d, w_vs});
                    r_bl_d <= PIPE'({r_bl_d, w_active});
                end
            end

            assign hsync = r_hs_d[PIPE-1];
            assign vsync = r_vs_d[PIPE-1];
            assign blank = r_bl_d[PIPE-1];
        end
    endgenerate

    assign pix_ce    = w_ce;
    assign vga_clk   = r_vga_clk;
    assign pixelx    = r_x;
    assign pixely    = r_y;
    assign active    = w_active;
    assign sync      = 1'b0;
    assign sof       = w_ce & w_x_last & w_y_last;
    assign frame_cnt = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default 640x480 timing
// (PIPE 1 and 0), a tiny raster with PIPE=2, and a 2-bit frame counter build.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Default geometry, PIPE=1 (a_) and PIPE=0 (p_), sharing rst_a/en_a
    logic       rst_a, en_a;
    logic       a_ce, a_vclk, a_act, a_hs, a_vs, a_bl, a_sync, a_sof;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       p_ce, p_vclk, p_act, p_hs, p_vs, p_bl, p_sync, p_sof;
    logic [9:0] p_x, p_y;
    logic [7:0] p_fc;

    // Tiny raster 8x6, CLK_DIV=1, hsync active-high, PIPE=2
    logic       rst_s, en_s;
    logic       s_ce, s_vclk, s_act, s_hs, s_vs, s_bl, s_sync, s_sof;
    logic [2:0] s_x, s_y;
    logic [7:0] s_fc;

    // Tiny raster, CLK_DIV=3, FRAME_W=2, PIPE=0
    logic       rst_f, en_f;
    logic       f_ce, f_vclk, f_act, f_hs, f_vs, f_bl, f_sync, f_sof;
    logic [2:0] f_x, f_y;
    logic [1:0] f_fc;

    vga_timing_gen #(.PIPE(1)) u_def (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_ce(a_ce), .vga_clk(a_vclk),
        .pixelx(a_x), .pixely(a_y), .active(a_act), .hsync(a_hs), .vsync(a_vs),
        .blank(a_bl), .sync(a_sync), .sof(a_sof), .frame_cnt(a_fc)
    );

    vga_timing_gen #(.PIPE(0)) u_p0 (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_ce(p_ce), .vga_clk(p_vclk),
        .pixelx(p_x), .pixely(p_y), .active(p_act), .hsync(p_hs), .vsync(p_vs),
        .blank(p_bl), .sync(p_sync), .sof(p_sof), .frame_cnt(p_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1), .PIPE(2)
    ) u_small (
        .clk(clk), .rst(rst_s), .en(en_s), .pix_ce(s_ce), .vga_clk(s_vclk),
        .pixelx(s_x), .pixely(s_y), .active(s_act), .hsync(s_hs), .vsync(s_vs),
        .blank(s_bl), .sync(s_sync), .sof(s_sof), .frame_cnt(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .PIPE(0), .FRAME_W(2)
    ) u_f2 (
        .clk(clk), .rst(rst_f), .en(en_f), .pix_ce(f_ce), .vga_clk(f_vclk),
        .pixelx(f_x), .pixely(f_y), .active(f_act), .hsync(f_hs), .vsync(f_vs),
        .blank(f_bl), .sync(f_sync), .sof(f_sof), .frame_cnt(f_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int   t0, a_lo, a_min, a_max, p_lo, p_min, p_max, p_blbad, vclk_hi, a_blhi;
    int   bad, sof_n, sof_k0, sof_k1, fc49, hs_hi, bl_hi, vs_lo, lag_bad;
    int   prev_fc, nchg, t_first, t_last, f_hsbad, f_sof_n, f_sof_wide, f_vhi;
    logic prev_sof;
    logic act_hist [0:127];
    int   fc_seq [5];
    int   fc_exp [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_a = 1'b1; en_a = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        rst_f = 1'b1; en_f = 1'b0;
        repeat (3) tick();

        // Reset state, default geometry
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_pix_ce", a_ce, 0);
        check("rst_vga_clk", a_vclk, 0);
        check("rst_hsync", a_hs, 1);
        check("rst_vsync", a_vs, 1);
        check("rst_blank", a_bl, 0);
        check("rst_sof", a_sof, 0);
        check("rst_frame_cnt", a_fc, 0);
        check("sync_const", a_sync, 0);
        check("rst_p0_hsync", p_hs, 1);

        rst_a = 1'b0; en_a = 1'b1;
        tick();
        check("e1_pix_ce", a_ce, 0);
        check("e1_vga_clk", a_vclk, 0);
        tick();
        check("e2_pix_ce", a_ce, 1);
        check("e2_vga_clk", a_vclk, 1);
        check("e2_x", a_x, 0);
        tick();
        check("e3_pix_ce", a_ce, 0);
        check("e3_x", a_x, 1);

        // One full line: measure length, hsync window and blank occupancy
        t0 = cyc;
        a_lo = 0; a_min = 9999; a_max = -1;
        p_lo = 0; p_min = 9999; p_max = -1;
        p_blbad = 0; vclk_hi = 0; a_blhi = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (a_hs === 1'b0) begin
                a_lo++;
                if (int'(a_x) < a_min) a_min = int'(a_x);
                if (int'(a_x) > a_max) a_max = int'(a_x);
            end
            if (p_hs === 1'b0) begin
                p_lo++;
                if (int'(p_x) < p_min) p_min = int'(p_x);
                if (int'(p_x) > p_max) p_max = int'(p_x);
            end
            if (p_bl !== p_act) p_blbad++;
            if (a_vclk === 1'b1) vclk_hi++;
            if (a_bl === 1'b1) a_blhi++;
            if (a_y == 10'd1 && a_x == 10'd1) break;
        end
        check("line_clk", cyc - t0, 1600);
        check("pipe1_hs_low_cnt", a_lo, 192);
        check("pipe1_hs_first", a_min, 657);
        check("pipe1_hs_last", a_max, 752);
        check("pipe0_hs_low_cnt", p_lo, 192);
        check("pipe0_hs_first", p_min, 656);
        check("pipe0_hs_last", p_max, 751);
        check("pipe0_blank_eq_active", p_blbad, 0);
        check("vga_clk_high_cnt", vclk_hi, 800);
        check("pipe1_blank_cnt", a_blhi, 1280);

        // Freeze with a pixel enable pending at pixelx=100
        for (int i = 0; i < 400; i++) begin
            if (a_x == 10'd100 && a_ce === 1'b1) break;
            tick();
        end
        check("pre_freeze_x", a_x, 100);
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (a_x != 10'd100 || a_y != 10'd1 || a_ce !== 1'b0 || a_vclk !== 1'b1 ||
                a_hs !== 1'b1 || a_bl !== 1'b1 || p_x != 10'd100 || p_ce !== 1'b0)
                bad++;
        end
        check("freeze_hold", bad, 0);
        en_a = 1'b1;
        tick();
        check("resume_x", a_x, 101);
        check("resume_vga_clk", a_vclk, 0);
        tick();
        check("resume_pix_ce", a_ce, 1);
        check("resume_x_hold", a_x, 101);
        tick();
        check("resume_next_x", a_x, 102);

        // Reset in the middle of an active line
        for (int i = 0; i < 1200; i++) begin
            if (a_x == 10'd500) break;
            tick();
        end
        check("pre_rst_blank", a_bl, 1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("midrst_x", a_x, 0);
        check("midrst_y", a_y, 0);
        check("midrst_hsync", a_hs, 1);
        check("midrst_vsync", a_vs, 1);
        check("midrst_blank", a_bl, 0);
        check("midrst_sof", a_sof, 0);
        check("midrst_frame_cnt", a_fc, 0);
        check("midrst_pix_ce", a_ce, 0);
        check("midrst_p0_hsync", p_hs, 1);

        // Tiny raster: two frames, sof spacing, PIPE=2 lag
        rst_s = 1'b0; en_s = 1'b1;
        tick();
        check("s_e1_pix_ce", s_ce, 1);
        check("s_e1_x", s_x, 0);
        check("s_e1_sof", s_sof, 0);
        act_hist[1] = s_act;
        sof_n = 0; sof_k0 = -1; sof_k1 = -1; fc49 = -1;
        hs_hi = 0; bl_hi = 0; vs_lo = 0; lag_bad = 0;
        for (int k = 2; k <= 100; k++) begin
            tick();
            act_hist[k] = s_act;
            if (s_sof === 1'b1) begin
                sof_n++;
                if (sof_k0 < 0) sof_k0 = k;
                else sof_k1 = k;
            end
            if (k == 49) fc49 = int'(s_fc);
            if (k >= 49 && k <= 96) begin
                if (s_hs === 1'b1) hs_hi++;
                if (s_bl === 1'b1) bl_hi++;
                if (s_vs === 1'b0) vs_lo++;
                if (s_bl !== act_hist[k-2]) lag_bad++;
            end
        end
        check("s_sof_count", sof_n, 2);
        check("s_sof_first", sof_k0, 48);
        check("s_sof_gap", sof_k1 - sof_k0, 48);
        check("s_fc_after_sof", fc49, 1);
        check("s_fc_two_frames", s_fc, 2);
        check("s_hs_high_cnt", hs_hi, 12);
        check("s_blank_cnt", bl_hi, 12);
        check("s_vs_low_cnt", vs_lo, 8);
        check("s_blank_lag2", lag_bad, 0);

        for (int i = 0; i < 60; i++) begin
            if (s_y == 3'd3 && s_x == 3'd2) break;
            tick();
        end
        check("s_pre_rst_y", s_y, 3);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        check("s_midrst_x", s_x, 0);
        check("s_midrst_y", s_y, 0);
        check("s_midrst_hsync", s_hs, 0);
        check("s_midrst_vsync", s_vs, 1);
        check("s_midrst_blank", s_bl, 0);
        check("s_midrst_sof", s_sof, 0);
        check("s_midrst_frame_cnt", s_fc, 0);

        // 2-bit frame counter over five frames, CLK_DIV=3
        rst_f = 1'b0; en_f = 1'b1;
        for (int i = 0; i < 5; i++) fc_seq[i] = -1;
        prev_fc = 0; nchg = 0; t_first = -1; t_last = -1;
        f_hsbad = 0; f_sof_n = 0; f_sof_wide = 0; prev_sof = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (f_sof === 1'b1) begin
                f_sof_n++;
                if (prev_sof === 1'b1) f_sof_wide++;
            end
            prev_sof = f_sof;
            if ((f_hs === 1'b0) != (f_x >= 3'd5 && f_x <= 3'd6)) f_hsbad++;
            if (int'(f_fc) != prev_fc) begin
                if (nchg < 5) fc_seq[nchg] = int'(f_fc);
                if (nchg == 0) t_first = cyc;
                t_last = cyc;
                nchg++;
                prev_fc = int'(f_fc);
            end
            if (nchg == 5) break;
        end
        for (int i = 0; i < 5; i++) check($sformatf("f_fc_seq%0d", i), fc_seq[i], fc_exp[i]);
        check("f_frame_clk", t_last - t_first, 4 * 144);
        check("f_sof_count", f_sof_n, 5);
        check("f_sof_width", f_sof_wide, 0);
        check("f_hs_window", f_hsbad, 0);
        f_vhi = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (f_vclk === 1'b1) f_vhi++;
        end
        check("f_vga_clk_duty", f_vhi, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
